// File: rtl/video_frame_source_arbiter_if.sv
// Avalon-ST video stream bundle: pixel word plus SOP/EOP framing and valid/ready handshake.
interface video_frame_source_arbiter_if #(
    parameter int NumColourBits = 12
);
    logic [NumColourBits-1:0] data;
    logic                     startofpacket;
    logic                     endofpacket;
    logic                     valid;
    logic                     ready;

    modport master (output data, startofpacket, endofpacket, valid, input ready);
    modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/video_frame_source_arbiter.sv
// Two-source Avalon-ST video arbiter that switches sources only on frame boundaries.
// Optional frame-length checking is enabled by defining FRAME_LENGTH_CHECK_EN.
module video_frame_source_arbiter #(
    parameter int NumPixels     = 640*480,
    parameter int NumColourBits = 12
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                sel,
    video_frame_source_arbiter_if.slave         src0,
    video_frame_source_arbiter_if.slave         src1,
    video_frame_source_arbiter_if.master        sink,
    output logic                                active_src,
    output logic                                frame_done,
    output logic                                frame_error
);
    localparam int W = $clog2(NumPixels + 1);

    typedef enum logic {ALIGN, STREAM} state_t;

    state_t                   state;
    logic [W-1:0]             count;

    logic [NumColourBits-1:0] a_data;
    logic                     a_sop, a_eop, a_valid, a_ready;
    logic                     hs;
    logic                     len_bad_eop, len_overrun;

    assign a_data  = active_src ? src1.data          : src0.data;
    assign a_sop   = active_src ? src1.startofpacket : src0.startofpacket;
    assign a_eop   = active_src ? src1.endofpacket   : src0.endofpacket;
    assign a_valid = active_src ? src1.valid         : src0.valid;

    assign sink.data          = a_data;
    assign sink.startofpacket = a_sop;
    assign sink.endofpacket   = a_eop;

    // While aligning, non-SOP beats are swallowed so the sink only ever sees whole frames.
    always_comb begin
        sink.valid = 1'b0;
        a_ready    = 1'b0;
        if (state == ALIGN) begin
            sink.valid = a_valid & a_sop;
            a_ready    = a_sop ? sink.ready : 1'b1;
        end else begin
            sink.valid = a_valid;
            a_ready    = sink.ready;
        end
        if (!reset) begin
            sink.valid = 1'b0;
            a_ready    = 1'b0;
        end
    end

    assign src0.ready = reset & (active_src  | a_ready);
    assign src1.ready = reset & (!active_src | a_ready);

    assign hs = sink.valid & sink.ready;

`ifdef FRAME_LENGTH_CHECK_EN
    logic [W:0] count_inc;
    assign count_inc   = {1'b0, count} + 1'b1;
    assign len_bad_eop = (count_inc != (W+1)'(NumPixels));
    assign len_overrun = (count_inc == (W+1)'(NumPixels));
`else
    assign len_bad_eop = 1'b0;
    assign len_overrun = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ALIGN;
            active_src  <= 1'b0;
            count       <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ALIGN: begin
                    active_src <= sel;
                    if (hs) begin
                        if (a_eop) begin
                            frame_done <= 1'b1;
                            count      <= '0;
                            if (len_bad_eop) frame_error <= 1'b1;
                        end else begin
                            // Lock the owner for the frame that just started.
                            active_src <= active_src;
                            count      <= W'(1);
                            state      <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (a_eop) begin
                            frame_done <= 1'b1;
                            count      <= '0;
                            state      <= ALIGN;
                            active_src <= sel;
                            if (len_bad_eop) frame_error <= 1'b1;
                        end else if (len_overrun) begin
                            // Frame ran past its nominal length: drop the rest until the next SOP.
                            frame_error <= 1'b1;
                            count       <= '0;
                            state       <= ALIGN;
                            active_src  <= sel;
                        end else if (count != '1) begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= ALIGN;
            endcase
        end
    end
endmodule
